// File: rtl/motor_ramp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : motor_ramp_scheduler
// Description : Avalon-MM write master for the 6-motor PWM slave register map
//               (addr 0-5 = {dir, on} per motor, addr 8-13 = duty per motor).
//               The host posts a target direction/duty per motor. On every
//               ramp tick each motor's applied duty is slewed toward its target
//               by at most RAMP_STEP. A direction change first ramps the duty
//               to 0, then writes the new direction, then ramps up again.
//
// Ports       : clk, reset              clock, async active-high reset
//               tgt_valid/idx/dir/duty  host target update (idx 6-7 ignored)
//               tgt_ack                 pulse the cycle after an accepted update
//               avs_chipselect/write    one-cycle write strobe to the slave
//               avs_addr/avs_writedata  write address/data, 0 when not writing
//               busy                    scheduler outside IDLE
//               wdog_trip               host-silence watchdog tripped
//
// Options     : `define MOTOR_WATCHDOG_EN enables the host-silence watchdog.
//               Without it wdog_trip is tied low and WDOG_TICKS is only
//               range-checked.
//
// Revision    : 1.0 - initial release
// ============================================================================
module motor_ramp_scheduler #(
    parameter int DUTY_W     = 8,
    parameter int RAMP_DIV   = 50000,
    parameter int RAMP_STEP  = 4,
    parameter int WDOG_TICKS = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tgt_valid,
    input  logic [2:0]        tgt_idx,
    input  logic [1:0]        tgt_dir,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              tgt_ack,
    output logic              avs_chipselect,
    output logic              avs_write,
    output logic [3:0]        avs_addr,
    output logic [31:0]       avs_writedata,
    output logic              busy,
    output logic              wdog_trip
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_init    = 3'd0;
    localparam logic [2:0] c_st_idle    = 3'd1;
    localparam logic [2:0] c_st_eval    = 3'd2;
    localparam logic [2:0] c_st_wr_dir  = 3'd3;
    localparam logic [2:0] c_st_wr_duty = 3'd4;

    localparam int                 c_tick_w   = $clog2(RAMP_DIV);
    localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(RAMP_DIV - 1);
    localparam logic [DUTY_W-1:0]  c_step     = DUTY_W'(RAMP_STEP);
    localparam logic [2:0]         c_last_mtr = 3'd5;
    localparam logic [3:0]         c_init_end = 4'd11;

    // Elaboration-time parameter sanity check
    generate
        if (RAMP_DIV < 32 || RAMP_STEP < 1 || WDOG_TICKS < 1 || DUTY_W > 31) begin : g_param_check
            $error("motor_ramp_scheduler: illegal parameter value");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]          r_state, w_state_nxt;
    logic [2:0]          r_idx, w_idx_nxt;
    logic [3:0]          r_init_cnt, w_init_cnt_nxt;

    logic [1:0]          r_cur_dir  [6];
    logic [DUTY_W-1:0]   r_cur_duty [6];
    logic [1:0]          r_tgt_dir  [6];
    logic [DUTY_W-1:0]   r_tgt_duty [6];

    logic [c_tick_w-1:0] r_tick_cnt;
    logic                w_tick;
    logic                r_pending;
    logic                w_pend_clr;

    logic                w_accept;
    logic [DUTY_W-1:0]   w_load_duty;
    logic                w_force_zero;

    logic                w_wr;
    logic [3:0]          w_addr;
    logic [31:0]         w_data;
    logic                w_duty_we;
    logic                w_dir_we;
    logic [DUTY_W-1:0]   w_duty_new;
    logic [DUTY_W-1:0]   w_cur;
    logic [DUTY_W-1:0]   w_tgt;
    logic [DUTY_W-1:0]   w_diff;
    logic                w_sweep_last;

    assign w_accept     = tgt_valid && (tgt_idx < 3'd6);
    assign w_tick       = (r_tick_cnt == c_tick_max);
    assign w_cur        = r_cur_duty[r_idx];
    assign w_tgt        = r_tgt_duty[r_idx];
    assign w_sweep_last = (r_idx == c_last_mtr);

    // ------------------------------------------------------------------------
    // Host-silence watchdog
    // ------------------------------------------------------------------------
`ifdef MOTOR_WATCHDOG_EN
    localparam int                  c_wdog_w   = $clog2(WDOG_TICKS + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_lim = c_wdog_w'(WDOG_TICKS - 1);

    logic [c_wdog_w-1:0] r_wdog_cnt;
    logic                r_wdog_trip;

    // An accepted update always wins over a coincident tick, so a trip can
    // never coincide with a target load.
    assign w_force_zero = w_tick && !w_accept && !r_wdog_trip && (r_wdog_cnt == c_wdog_lim);
    // The update that clears a trip still loads duty 0.
    assign w_load_duty  = r_wdog_trip ? '0 : tgt_duty;
    assign wdog_trip    = r_wdog_trip;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog_cnt  <= '0;
            r_wdog_trip <= 1'b0;
        end else if (w_accept) begin
            r_wdog_cnt  <= '0;
            r_wdog_trip <= 1'b0;
        end else if (w_tick && !r_wdog_trip) begin
            r_wdog_cnt  <= r_wdog_cnt + 1'b1;
            r_wdog_trip <= w_force_zero;
        end
    end
`else
    assign w_force_zero = 1'b0;
    assign w_load_duty  = tgt_duty;
    assign wdog_trip    = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Ramp tick divider and pending-tick latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            // In IDLE a tick is consumed directly (w_pend_clr is set), so only
            // ticks arriving mid-sweep or during INIT remain pending.
            if (w_pend_clr)
                r_pending <= 1'b0;
            else if (w_tick)
                r_pending <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Host target registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                r_tgt_dir[i]  <= '0;
                r_tgt_duty[i] <= '0;
            end
            tgt_ack <= 1'b0;
        end else begin
            tgt_ack <= w_accept;
            if (w_force_zero) begin
                for (int i = 0; i < 6; i++)
                    r_tgt_duty[i] <= '0;
            end
            if (w_accept) begin
                r_tgt_dir[tgt_idx]  <= tgt_dir;
                r_tgt_duty[tgt_idx] <= w_load_duty;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM state and applied per-motor state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_init;
            r_idx      <= '0;
            r_init_cnt <= '0;
            for (int i = 0; i < 6; i++) begin
                r_cur_dir[i]  <= '0;
                r_cur_duty[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            if (w_duty_we)
                r_cur_duty[r_idx] <= w_duty_new;
            if (w_dir_we)
                r_cur_dir[r_idx]  <= r_tgt_dir[r_idx];
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, sweep evaluation and write request
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_init_cnt_nxt = r_init_cnt;
        w_pend_clr     = 1'b0;
        w_wr           = 1'b0;
        w_addr         = '0;
        w_data         = '0;
        w_duty_we      = 1'b0;
        w_dir_we       = 1'b0;
        w_duty_new     = w_cur;
        w_diff         = '0;

        case (r_state)
            c_st_init: begin
                // Zero dir registers 0..5, then duty registers 8..13.
                w_wr   = 1'b1;
                w_addr = (r_init_cnt < 4'd6) ? r_init_cnt : r_init_cnt + 4'd2;
                if (r_init_cnt == c_init_end) begin
                    w_init_cnt_nxt = '0;
                    w_state_nxt    = c_st_idle;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 4'd1;
                end
            end

            c_st_idle: begin
                if (w_tick || r_pending) begin
                    w_pend_clr  = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = c_st_eval;
                end
            end

            c_st_eval: begin
                if (r_tgt_dir[r_idx] != r_cur_dir[r_idx]) begin
                    if (w_cur != '0) begin
                        // Reversal: bring duty to zero before touching dir.
                        w_duty_we   = 1'b1;
                        w_duty_new  = w_cur - ((w_cur > c_step) ? c_step : w_cur);
                        w_state_nxt = c_st_wr_duty;
                    end else begin
                        w_dir_we    = 1'b1;
                        w_state_nxt = c_st_wr_dir;
                    end
                end else if (w_cur < w_tgt) begin
                    w_diff      = w_tgt - w_cur;
                    w_duty_we   = 1'b1;
                    w_duty_new  = w_cur + ((w_diff > c_step) ? c_step : w_diff);
                    w_state_nxt = c_st_wr_duty;
                end else if (w_cur > w_tgt) begin
                    w_diff      = w_cur - w_tgt;
                    w_duty_we   = 1'b1;
                    w_duty_new  = w_cur - ((w_diff > c_step) ? c_step : w_diff);
                    w_state_nxt = c_st_wr_duty;
                end else begin
                    if (w_sweep_last) begin
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = c_st_eval;
                    end
                end
            end

            c_st_wr_dir, c_st_wr_duty: begin
                w_wr = 1'b1;
                if (r_state == c_st_wr_dir) begin
                    w_addr = {1'b0, r_idx};
                    w_data = {30'd0, r_cur_dir[r_idx]};
                end else begin
                    w_addr = {1'b1, r_idx};
                    w_data = {{(32-DUTY_W){1'b0}}, w_cur};
                end
                if (w_sweep_last) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_state_nxt = c_st_eval;
                end
            end

            default: begin
                w_state_nxt = c_st_init;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered bus outputs: the write decided in a state is presented on the
    // bus during the following cycle, so everything drops to 0 the moment
    // reset asserts.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_chipselect <= 1'b0;
            avs_write      <= 1'b0;
            avs_addr       <= '0;
            avs_writedata  <= '0;
            busy           <= 1'b0;
        end else begin
            avs_chipselect <= w_wr;
            avs_write      <= w_wr;
            avs_addr       <= w_addr;
            avs_writedata  <= w_data;
            busy           <= (r_state != c_st_idle);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_ramp_scheduler
// Description : Self-checking bench for motor_ramp_scheduler. Expected slave
//               writes are queued when a target is posted and compared as the
//               DUT issues them; a table drives the main ramp cases and short
//               hand-written sequences cover the timing corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_ramp_scheduler;

    localparam int c_ramp_div  = 32;
    localparam int c_ramp_step = 4;
    localparam int c_wdog      = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        tgt_valid;
    logic [2:0]  tgt_idx;
    logic [1:0]  tgt_dir;
    logic [7:0]  tgt_duty;
    logic        tgt_ack;
    logic        avs_chipselect;
    logic        avs_write;
    logic [3:0]  avs_addr;
    logic [31:0] avs_writedata;
    logic        busy;
    logic        wdog_trip;

    always #5 clk = ~clk;

    motor_ramp_scheduler #(
        .DUTY_W     (8),
        .RAMP_DIV   (c_ramp_div),
        .RAMP_STEP  (c_ramp_step),
        .WDOG_TICKS (c_wdog)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tgt_valid      (tgt_valid),
        .tgt_idx        (tgt_idx),
        .tgt_dir        (tgt_dir),
        .tgt_duty       (tgt_duty),
        .tgt_ack        (tgt_ack),
        .avs_chipselect (avs_chipselect),
        .avs_write      (avs_write),
        .avs_addr       (avs_addr),
        .avs_writedata  (avs_writedata),
        .busy           (busy),
        .wdog_trip      (wdog_trip)
    );

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [2:0]      idx;
        logic [1:0]      dir;
        logic [7:0]      duty;
        logic [3:0]      n;
        logic [0:5][3:0] a;
        logic [0:5][7:0] d;
    } vec_t;

    wr_t        exp_q[$];
    vec_t       tbl[6];
    int         checks;
    int         errors;
    logic       mon_en;
    logic [7:0] obs_duty[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back({a, 24'd0, d});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Post a target on a negedge+1 slot and check the one-cycle ack.
    task automatic post(input logic [2:0] idx, input logic [1:0] dir,
                        input logic [7:0] duty, input logic exp_ack);
        tgt_valid = 1'b1;
        tgt_idx   = idx;
        tgt_dir   = dir;
        tgt_duty  = duty;
        @(negedge clk);
        #1;
        check("ack", {31'd0, tgt_ack}, {31'd0, exp_ack});
        tgt_valid = 1'b0;
        @(negedge clk);
        #1;
        check("ack_drop", {31'd0, tgt_ack}, 32'd0);
    endtask

    // Wait until every queued write has been seen, bounded by a cycle budget.
    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({"drain_", name}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic release_reset();
        for (int i = 0; i < 6; i++) begin
            push_wr(4'(i), 8'd0);
            obs_duty[i] = 8'd0;
        end
        for (int i = 0; i < 6; i++)
            push_wr(4'(8 + i), 8'd0);
        mon_en = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        #1;
        check("busy_in_init", {31'd0, busy}, 32'd1);
        drain("init", 40);
        wait_cycles(2);
        check("busy_after_init", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        reset     = 1'b1;
        tgt_valid = 1'b0;
        tgt_idx   = '0;
        tgt_dir   = '0;
        tgt_duty  = '0;
        for (int i = 0; i < 6; i++)
            obs_duty[i] = 8'd0;

        tbl[0] = '{idx:3'd2, dir:2'b01, duty:8'd10, n:4'd4,
                   a:{4'd2, 4'd10, 4'd10, 4'd10, 4'd0, 4'd0},
                   d:{8'd1, 8'd4, 8'd8, 8'd10, 8'd0, 8'd0}};
        tbl[1] = '{idx:3'd2, dir:2'b11, duty:8'd6, n:4'd6,
                   a:{4'd10, 4'd10, 4'd10, 4'd2, 4'd10, 4'd10},
                   d:{8'd6, 8'd2, 8'd0, 8'd3, 8'd4, 8'd6}};
        tbl[2] = '{idx:3'd5, dir:2'b10, duty:8'd3, n:4'd2,
                   a:{4'd5, 4'd13, 4'd0, 4'd0, 4'd0, 4'd0},
                   d:{8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0}};
        tbl[3] = '{idx:3'd5, dir:2'b10, duty:8'd0, n:4'd1,
                   a:{4'd13, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
                   d:{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        tbl[4] = '{idx:3'd0, dir:2'b01, duty:8'd7, n:4'd3,
                   a:{4'd0, 4'd8, 4'd8, 4'd0, 4'd0, 4'd0},
                   d:{8'd1, 8'd4, 8'd7, 8'd0, 8'd0, 8'd0}};
        tbl[5] = '{idx:3'd0, dir:2'b01, duty:8'd7, n:4'd0,
                   a:{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
                   d:{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};

        fork
            // Bus monitor: scoreboard compare, idle-bus and ordering checks.
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    check("cs_eq_write", {31'd0, avs_chipselect}, {31'd0, avs_write});
                    if (avs_write) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write actual=addr %0d data %0h required=no write t=%0t",
                                     avs_addr, avs_writedata, $time);
                        end else begin
                            wr_t e;
                            e = exp_q.pop_front();
                            check("wr_addr", {28'd0, avs_addr}, {28'd0, e.addr});
                            check("wr_data", avs_writedata, e.data);
                        end
                        if (avs_addr < 4'd6)
                            check("dir_with_duty", {24'd0, obs_duty[avs_addr[2:0]]}, 32'd0);
                        else if (avs_addr >= 4'd8 && avs_addr <= 4'd13)
                            obs_duty[avs_addr[2:0]] = avs_writedata[7:0];
                    end else begin
                        check("idle_addr", {28'd0, avs_addr}, 32'd0);
                        check("idle_data", avs_writedata, 32'd0);
                    end
                end
            end
            begin
                #2000000;
                $display("FAIL global_timeout actual=running required=finished");
                $fatal(1, "timeout");
            end
        join_none

        // Reset values
        wait_cycles(3);
        check("rst_cs", {31'd0, avs_chipselect}, 32'd0);
        check("rst_write", {31'd0, avs_write}, 32'd0);
        check("rst_addr", {28'd0, avs_addr}, 32'd0);
        check("rst_data", avs_writedata, 32'd0);
        check("rst_ack", {31'd0, tgt_ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wdog", {31'd0, wdog_trip}, 32'd0);

        release_reset();

        // Out-of-range index: no ack, no writes over the next ticks.
        post(3'd7, 2'b11, 8'd50, 1'b0);
        wait_cycles(2 * c_ramp_div + 8);

        // Table-driven ramps
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 6; k++)
                if (k < int'(tbl[i].n))
                    push_wr(tbl[i].a[k], tbl[i].d[k]);
            post(tbl[i].idx, tbl[i].dir, tbl[i].duty, 1'b1);
            drain($sformatf("vec%0d", i), 12 * c_ramp_div);
            wait_cycles(2 * c_ramp_div + 8);
        end

        // Update motor 5 while the sweep is evaluating motor 5: it must only
        // take effect on the next tick, after motor 4's second duty write.
        begin
            int k;
            push_wr(4'd4, 8'd1);
            push_wr(4'd12, 8'd4);
            push_wr(4'd12, 8'd8);
            push_wr(4'd13, 8'd2);
            post(3'd4, 2'b01, 8'd8, 1'b1);
            k = 0;
            while (!(avs_write && avs_addr == 4'd12) && k < 4 * c_ramp_div) begin
                @(negedge clk);
                #1;
                k++;
            end
            check("seen_wr12", {31'd0, avs_write}, 32'd1);
            post(3'd5, 2'b10, 8'd2, 1'b1);
            drain("eval5", 8 * c_ramp_div);
            wait_cycles(2 * c_ramp_div + 8);
        end

        // Reset asserted while a duty write is on the bus.
        begin
            int k;
            push_wr(4'd1, 8'd1);
            push_wr(4'd9, 8'd4);
            post(3'd1, 2'b01, 8'd8, 1'b1);
            k = 0;
            while (!(avs_write && avs_addr == 4'd9) && k < 4 * c_ramp_div) begin
                @(negedge clk);
                #1;
                k++;
            end
            check("seen_wr9", {31'd0, avs_write}, 32'd1);
            #1;
            reset = 1'b1;
            #1;
            check("async_write", {31'd0, avs_write}, 32'd0);
            check("async_cs", {31'd0, avs_chipselect}, 32'd0);
            check("async_addr", {28'd0, avs_addr}, 32'd0);
            check("async_data", avs_writedata, 32'd0);
            mon_en = 1'b0;
            exp_q.delete();
            wait_cycles(3);
            release_reset();
            wait_cycles(2 * c_ramp_div + 8);
        end

`ifdef MOTOR_WATCHDOG_EN
        // Ramp motor 0 to 12, let the host go silent until the watchdog trips,
        // then the motor ramps down to 0.
        push_wr(4'd0, 8'd1);
        push_wr(4'd8, 8'd4);
        push_wr(4'd8, 8'd8);
        push_wr(4'd8, 8'd12);
        post(3'd0, 2'b01, 8'd12, 1'b1);
        check("wdog_before", {31'd0, wdog_trip}, 32'd0);
        push_wr(4'd8, 8'd8);
        push_wr(4'd8, 8'd4);
        push_wr(4'd8, 8'd0);
        drain("wdog_ramp", (c_wdog + 10) * c_ramp_div);
        check("wdog_tripped", {31'd0, wdog_trip}, 32'd1);
        // Clearing update is itself forced to duty 0: no writes follow.
        post(3'd0, 2'b01, 8'd20, 1'b1);
        check("wdog_cleared", {31'd0, wdog_trip}, 32'd0);
        wait_cycles(2 * c_ramp_div + 8);
        push_wr(4'd8, 8'd4);
        post(3'd0, 2'b01, 8'd4, 1'b1);
        drain("wdog_after", 4 * c_ramp_div);
        check("wdog_still_clear", {31'd0, wdog_trip}, 32'd0);
`else
        check("wdog_tied", {31'd0, wdog_trip}, 32'd0);
`endif

        wait_cycles(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_ramp_scheduler.md
Name: motor_ramp_scheduler

Overview:
Avalon-MM write master that drives the 6-motor PWM slave register map. Map: addr 0-5 = {dir, on} per motor; addr 8-13 = duty per motor. Host logic posts target direction and duty per motor; the block slews each motor's applied duty toward its target in bounded steps on a periodic ramp tick. On a reversal it forces the motor through duty 0 before changing direction. Sits between the control/CPU side and the motor slave's chipselect/write/addr/writedata inputs.

Parameters:
DUTY_W, 8, duty width; must equal `DUTY_CYCLE_SIZE
RAMP_DIV, 50000, clk cycles per ramp tick (>=32)
RAMP_STEP, 4, max duty change per motor per tick (>=1)
WDOG_TICKS, 100, ramp ticks without host update before watchdog trip (used only with MOTOR_WATCHDOG_EN)

Ports:
clk  in  1  system clock
reset  in  1  async reset, active-high
tgt_valid  in  1  host target update strobe
tgt_idx  in  3  motor index 0-5; values 6-7 ignored
tgt_dir  in  2  target {dir, on} bits
tgt_duty  in  DUTY_W  target duty
tgt_ack  out  1  one-cycle pulse, cycle after an accepted update
avs_chipselect  out  1  to slave chipselect
avs_write  out  1  to slave write
avs_addr  out  4  to slave addr
avs_writedata  out  32  to slave writedata; upper bits zero
busy  out  1  high while not in IDLE
wdog_trip  out  1  watchdog tripped

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: all outputs 0. Per-motor cur_dir, cur_duty, tgt_dir and tgt_duty = 0. Tick counter = 0. FSM = INIT.
- Every write asserts chipselect and write together for exactly 1 cycle. No waitrequest. Max one write per cycle. addr and writedata are valid only while write=1 and are 0 otherwise.
- INIT, after reset release: 12 back-to-back writes, addr 0..5 with data 0, then addr 8..13 with data 0. Then go to IDLE.
- Target update:
  - tgt_valid with tgt_idx<6 is accepted in any state and loads tgt_dir/tgt_duty for that motor.
  - tgt_ack pulses the next cycle.
  - idx 6-7: no load, no ack.
  - An update to the motor being evaluated in the same cycle takes effect on that motor's next tick.
- Tick: a counter wraps at RAMP_DIV-1 and pulses tick. A tick raised outside IDLE is latched as pending; at most 1 pending, extras dropped.
- IDLE -> EVAL(i=0) on tick or pending.
- EVAL(i), 1 cycle, first matching rule applies:
  - (a) tgt_dir!=cur_dir and cur_duty>0: cur_duty -= min(RAMP_STEP, cur_duty); go to WR_DUTY.
  - (b) tgt_dir!=cur_dir and cur_duty==0: cur_dir <= tgt_dir; go to WR_DIR.
  - (c) cur_duty<tgt_duty: += min(step, diff). cur_duty>tgt_duty: -= min(step, diff). Saturating, never overshoots; go to WR_DUTY.
  - (d) equal: no write; go to NEXT.
- WR_DIR: addr=i, data=cur_dir.
- WR_DUTY: addr=8+i, data=cur_duty (new value).
- After WR_DIR, WR_DUTY or (d): i==5 -> IDLE, else EVAL(i+1).
- Worst-case sweep: 12 cycles, far below RAMP_DIV.
- Ordering: a dir write is never issued while the applied duty is nonzero.
- Reset mid-operation: the write in flight is dropped and all state clears. INIT re-runs after release.

Optional Feature:
MOTOR_WATCHDOG_EN:
- Defined:
  - A counter increments per tick and clears on any accepted tgt_valid.
  - Reaching WDOG_TICKS sets wdog_trip and forces all tgt_duty to 0; tgt_dir is unchanged, so motors ramp down normally.
  - While tripped, tgt_duty loads are still accepted but held at 0.
  - The next accepted tgt_valid clears the trip. That update's duty applies from the following update onward; the update itself is forced to 0.
- Undefined: wdog_trip tied to 0, no counter, WDOG_TICKS unused.

Test Plan:
- Release reset -> exactly 12 single-cycle writes: addr 0-5 then 8-13, all data 0, then busy=0.
- RAMP_DIV=32, STEP=4; motor 2 tgt dir=01, duty=10:
  - tick 1: write addr 2 data 1
  - ticks 2-4: writes addr 10 with data 4, 8, 10
  - no further writes.
- Motor 2 at dir 01 / duty 10, retarget dir=11 duty 6 -> addr10 data 6, 2, 0; then addr2 data 3; then addr10 data 4, 6. No dir write while duty nonzero.
- tgt_valid idx=7 -> no ack, no state change. tgt_valid idx=5 in EVAL(5) -> ack next cycle; applied on the following tick.
- Assert reset during WR_DUTY -> outputs 0 asynchronously; INIT sequence repeats after release.
- MOTOR_WATCHDOG_EN, WDOG_TICKS=3, motor 0 at duty 12: no updates for 3 ticks -> wdog_trip=1, then addr8 data 8, 4, 0. Next tgt_valid -> wdog_trip=0.
